// File: rtl/m2sram_stride_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : m2sram_stride_ctrl
//  Function : Dual-bank M2SRAM frame controller. Writes a 16-sample frame in
//             natural order (two samples per beat) using a bank-skewed layout,
//             then reads it back as stride-8 pairs (x[j], x[j+N/2]).
//  Revision : 1.0  initial release
// ============================================================================
module m2sram_stride_ctrl #(
   parameter int DW = 64,
   parameter int AW = 3
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   input  logic [DW-1:0] i_din0,
   input  logic [DW-1:0] i_din1,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [DW-1:0] o_dout0,
   output logic [DW-1:0] o_dout1,
   output logic          o_frame_done,
   output logic          o_we,
   output logic [AW-1:0] o_addr0,
   output logic [AW-1:0] o_addr1,
   output logic [DW-1:0] o_d0,
   output logic [DW-1:0] o_d1,
   input  logic [DW-1:0] i_q0,
   input  logic [DW-1:0] i_q1
);

   typedef enum logic [0:0] {
      S_FILL  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   localparam logic [AW-1:0] c_wlast = '1;
   localparam logic [AW-1:0] c_wone  = AW'(1);
   localparam logic [AW:0]   c_rone  = (AW+1)'(1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_wcnt;
   logic [AW:0]   r_rcnt;      // reaches 2^AW once every read has been issued
   logic          r_p;         // j[0] of the beat currently held in Q
   logic          r_out_valid;
   logic [AW-1:0] r_addr0;     // last issued read addresses, replayed under stall
   logic [AW-1:0] r_addr1;

   logic          w_wr_acc;
   logic          w_issue;
   logic          w_last_acc;
   logic [AW-1:0] w_rd_lo;
   logic [AW-1:0] w_rd_hi;
   logic [AW-1:0] w_rd_addr0;
   logic [AW-1:0] w_rd_addr1;

   // Beat j reads x[j] (upper half-address 0) and x[j+N/2] (upper half-address 1);
   // odd beats find x[j] in bank 1, so the two addresses swap banks.
   assign w_rd_lo    = {1'b0, r_rcnt[AW-1:1]};
   assign w_rd_hi    = {1'b1, r_rcnt[AW-1:1]};
   assign w_rd_addr0 = r_rcnt[0] ? w_rd_hi : w_rd_lo;
   assign w_rd_addr1 = r_rcnt[0] ? w_rd_lo : w_rd_hi;

   // Next state, handshakes and memory address selection.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_acc    = 1'b0;
      w_issue     = 1'b0;
      w_last_acc  = 1'b0;
      o_in_ready  = 1'b0;
      o_addr0     = r_addr0;
      o_addr1     = r_addr1;
      case (r_state)
         S_FILL: begin
            o_in_ready = 1'b1;
            w_wr_acc   = i_in_valid;
            o_addr0    = r_wcnt;
            o_addr1    = r_wcnt;
            if (i_in_valid && (r_wcnt == c_wlast)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_issue    = ~r_rcnt[AW] & (~r_out_valid | i_out_ready);
            w_last_acc = r_rcnt[AW] & r_out_valid & i_out_ready;
            if (w_issue) begin
               o_addr0 = w_rd_addr0;
               o_addr1 = w_rd_addr1;
            end
            if (w_last_acc) begin
               w_state_nxt = S_FILL;
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   assign o_we         = w_wr_acc;
   assign o_frame_done = w_last_acc;
   assign o_out_valid  = r_out_valid;

   // Second half of the frame lands in the opposite banks, so swap the lanes.
   assign o_d0 = r_wcnt[AW-1] ? i_din1 : i_din0;
   assign o_d1 = r_wcnt[AW-1] ? i_din0 : i_din1;

   // Undo the bank swap of odd beats on the registered read data.
   assign o_dout0 = r_p ? i_q1 : i_q0;
   assign o_dout1 = r_p ? i_q0 : i_q1;

   // Phase register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Write beat counter; wraps to zero on the last beat of a frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wcnt <= '0;
      end else if (w_wr_acc) begin
         r_wcnt <= r_wcnt + c_wone;
      end
   end

   // Read issue counter, in-flight parity and held addresses.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rcnt  <= '0;
         r_p     <= 1'b0;
         r_addr0 <= '0;
         r_addr1 <= '0;
      end else if (w_issue) begin
         r_rcnt  <= r_rcnt + c_rone;
         r_p     <= r_rcnt[0];
         r_addr0 <= w_rd_addr0;
         r_addr1 <= w_rd_addr1;
      end else if (w_last_acc) begin
         r_rcnt  <= '0;
      end
   end

   // Output valid: set one cycle after an issue, cleared on acceptance otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
      end else if (w_issue) begin
         r_out_valid <= 1'b1;
      end else if (r_out_valid && i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_m2sram_stride_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m2sram_stride_ctrl
//  Function : Self-checking bench for m2sram_stride_ctrl with a dual-bank
//             memory model and a frame-level scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m2sram_stride_ctrl;
   localparam int DW = 64;
   localparam int AW = 3;
   localparam int NB = 8;             // beats per frame, also bank depth

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [DW-1:0] din0 = '0;
   logic [DW-1:0] din1 = '0;
   logic          in_ready, out_valid, frame_done, we;
   logic [DW-1:0] dout0, dout1, d0, d1;
   logic [DW-1:0] q0, q1;
   logic [AW-1:0] addr0, addr1;

   logic [DW-1:0] bank0 [NB];
   logic [DW-1:0] bank1 [NB];

   int n_pass = 0;
   int n_total = 0;
   bit rand_ready = 1'b0;

   // scoreboard state
   logic [127:0] exp_q[$];
   logic [DW-1:0] xf [2*NB];
   int  in_cnt = 0;
   int  out_idx = 0;
   int  frames_done = 0;
   bit  draining = 1'b0;
   bit  mem_chk = 1'b0;
   bit  prev_stall = 1'b0;
   bit  fill_now;
   int  mem_bad;
   logic [127:0] prev_dout;
   logic [127:0] exp_beat;

   typedef struct {
      logic          in_valid;
      logic [DW-1:0] din0;
      logic [DW-1:0] din1;
      logic [9:0]    exp_ctrl;   // {in_ready, we, addr0, addr1, out_valid, frame_done}
      logic          chk_wd;
      logic [127:0]  exp_wd;
      logic          chk_out;
      logic [127:0]  exp_out;
   } vec_t;
   vec_t tbl [2*NB+1];

   m2sram_stride_ctrl #(.DW(DW), .AW(AW)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_din0(din0), .i_din1(din1),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_dout0(dout0), .o_dout1(dout1),
      .o_frame_done(frame_done),
      .o_we(we), .o_addr0(addr0), .o_addr1(addr1),
      .o_d0(d0), .o_d1(d1),
      .i_q0(q0), .i_q1(q1)
   );

   always #5 clk = ~clk;

   // dual-bank memory: shared WE, registered read on WE=0 cycles
   always @(posedge clk) begin
      if (we) begin
         bank0[addr0] <= d0;
         bank1[addr1] <= d1;
      end else begin
         q0 <= bank0[addr0];
         q1 <= bank1[addr1];
      end
   end

   // random downstream backpressure during the random phase
   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // layout rule: sample n lives in bank n[0]^n[AW] at address n[AW:1]
   function automatic int bank_of(input int n);
      return (n & 1) ^ ((n / NB) & 1);
   endfunction
   function automatic int addr_of(input int n);
      return (n / 2) % NB;
   endfunction
   function automatic logic [DW-1:0] mem_word(input int n);
      return (bank_of(n) == 1) ? bank1[addr_of(n)] : bank0[addr_of(n)];
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
   endtask

   task automatic fail(input string name);
      n_total++;
      $display("FAIL %s: event not seen, required within cycle bound (t=%0t)", name, $time);
   endtask

   // scoreboard: collects accepted input frames and checks every output beat
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         in_cnt     = 0;
         out_idx    = 0;
         draining   = 1'b0;
         mem_chk    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         fill_now = !draining;
         if (mem_chk) begin
            mem_bad = 0;
            for (int n = 2*NB-1; n >= 0; n--) if (mem_word(n) !== xf[n]) mem_bad = n;
            check("mem_layout", 128'(mem_word(mem_bad)), 128'(xf[mem_bad]));
            mem_chk = 1'b0;
         end
         check("in_ready", 128'(in_ready), 128'(fill_now));
         check("we", 128'(we), 128'(in_valid && fill_now));
         if (fill_now) check("idle_out_valid", 128'(out_valid), 128'(0));
         if (prev_stall) begin
            check("stall_valid", 128'(out_valid), 128'(1));
            check("stall_dout", {dout0, dout1}, prev_dout);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail("unexpected_out_beat");
            else begin
               exp_beat = exp_q.pop_front();
               check("dout", {dout0, dout1}, exp_beat);
            end
            check("frame_done", 128'(frame_done), 128'(out_idx == NB-1));
            out_idx++;
            if (out_idx == NB) begin
               out_idx  = 0;
               draining = 1'b0;
               frames_done++;
            end
         end else begin
            check("frame_done_idle", 128'(frame_done), 128'(0));
         end
         if (in_valid && fill_now) begin
            xf[2*in_cnt]   = din0;
            xf[2*in_cnt+1] = din1;
            in_cnt++;
            if (in_cnt == NB) begin
               for (int j = 0; j < NB; j++) exp_q.push_back({xf[j], xf[j+NB]});
               draining = 1'b1;
               in_cnt   = 0;
               mem_chk  = 1'b1;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_dout  = {dout0, dout1};
      end
   end

   // caller is at posedge+1; returns at posedge+1 after acceptance
   task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int g = 0;
      in_valid = 1'b1; din0 = a; din1 = b;
      @(negedge clk);
      while (!in_ready && g < 300) begin g++; @(negedge clk); end
      if (g >= 300) fail("in_ready_timeout");
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   // mode 0: no bubbles, 1: alternating bubbles, 2: random bubbles
   task automatic send_frame(input logic [DW-1:0] base, input int mode);
      for (int k = 0; k < NB; k++) begin
         if (mode == 1 && k > 0) idle_cycle();
         if (mode == 2) while ($urandom_range(0, 2) == 0) idle_cycle();
         send_beat(base + DW'(2*k), base + DW'(2*k+1));
      end
   endtask

   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while ((draining || exp_q.size() != 0 || in_cnt != 0) && g < 400) begin
         g++; @(negedge clk);
      end
      if (g >= 400) fail("drain_timeout");
      @(posedge clk); #1;
   endtask

   // returns at the negedge where a beat with DOUT0 == v is accepted
   task automatic wait_beat(input logic [DW-1:0] v);
      int g = 0;
      @(negedge clk);
      while (!(out_valid && out_ready && dout0 == v) && g < 300) begin
         g++; @(negedge clk);
      end
      if (g >= 300) fail("beat_timeout");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: still running at t=%0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      // natural frame vectors, derived from the layout rule
      for (int c = 0; c <= 2*NB; c++) begin
         tbl[c].in_valid = (c < NB);
         tbl[c].din0     = (c < NB) ? DW'(2*c)   : '0;
         tbl[c].din1     = (c < NB) ? DW'(2*c+1) : '0;
         tbl[c].chk_wd   = (c < NB);
         tbl[c].exp_wd   = (bank_of(2*c) == 0) ? {64'(2*c), 64'(2*c+1)} : {64'(2*c+1), 64'(2*c)};
         if (c < NB) begin
            tbl[c].exp_ctrl = {1'b1, 1'b1, 3'(c), 3'(c), 1'b0, 1'b0};
            tbl[c].chk_out  = 1'b0;
            tbl[c].exp_out  = '0;
         end else begin
            k = (c - NB > NB-1) ? NB-1 : c - NB;
            tbl[c].exp_ctrl = {1'b0, 1'b0,
                               (bank_of(k) == 0) ? {3'(addr_of(k)), 3'(addr_of(k+NB))}
                                                 : {3'(addr_of(k+NB)), 3'(addr_of(k))},
                               1'(c > NB), 1'(c == 2*NB)};
            tbl[c].chk_out  = (c > NB);
            tbl[c].exp_out  = {64'(c-NB-1), 64'(c-1)};
         end
      end

      // reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_frame_done", 128'(frame_done), 128'(0));
      check("rst_we", 128'(we), 128'(0));
      check("rst_addr", 128'({addr0, addr1}), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      // natural frame, cycle by cycle
      for (int c = 0; c <= 2*NB; c++) begin
         @(posedge clk); #1;
         in_valid = tbl[c].in_valid; din0 = tbl[c].din0; din1 = tbl[c].din1;
         @(negedge clk);
         check($sformatf("tbl_ctrl[%0d]", c),
               128'({in_ready, we, addr0, addr1, out_valid, frame_done}), 128'(tbl[c].exp_ctrl));
         if (tbl[c].chk_wd)  check($sformatf("tbl_wdata[%0d]", c), {d0, d1}, tbl[c].exp_wd);
         if (tbl[c].chk_out) check($sformatf("tbl_dout[%0d]", c), {dout0, dout1}, tbl[c].exp_out);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      // alternating input bubbles
      send_frame(64'd200, 1);
      wait_idle();

      // backpressure on beat 3
      fork
         send_frame(64'd300, 0);
         begin
            wait_beat(64'd302);
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check("bp_valid", 128'(out_valid), 128'(1));
               check("bp_dout", {dout0, dout1}, {64'd303, 64'd311});
               check("bp_addr", 128'({addr0, addr1}), 128'({3'd5, 3'd1}));
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_idle();

      // back-to-back frames
      send_frame(64'd0, 0);
      send_frame(64'd100, 0);
      wait_idle();

      // input held valid with junk during drain
      send_frame(64'd400, 0);
      in_valid = 1'b1; din0 = 64'hDEAD; din1 = 64'hDEAD;
      begin
         int g = 0;
         @(negedge clk);
         check("ign_we", 128'(we), 128'(0));
         while (!frame_done && g < 40) begin
            g++; @(negedge clk);
            check("ign_we", 128'(we), 128'(0));
         end
         if (g >= 40) fail("ign_done_timeout");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_idle();

      // reset mid-drain after beat 2
      fork
         send_frame(64'd500, 0);
         wait_beat(64'd502);
      join
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", 128'(out_valid), 128'(0));
      check("rst_mid_in_ready", 128'(in_ready), 128'(1));
      check("rst_mid_frame_done", 128'(frame_done), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send_frame(64'd600, 0);
      wait_idle();

      // random data, bubbles and backpressure
      rand_ready = 1'b1;
      for (int f = 0; f < 6; f++) send_frame({$urandom, $urandom}, 2);
      wait_idle();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);

      check("frames_completed", 128'(frames_done), 128'(13));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
